// File: rtl/noc_vc_pkg.sv
// Shared NoC virtual-channel definitions.
// Used by the output VC selector and the input buffer.
package noc_vc_pkg;

  localparam int NUM_VC = 2;
  localparam int FLIT_W = 32;

  typedef logic vc_id_t;

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel flit FIFO.
// A push while full is taken only if the head pops the same cycle.
module vc_fifo
  import noc_vc_pkg::*;
#(
  parameter int DATA_W = FLIT_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr];

  // Flit storage; contents are don't-care until counted in.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vc_input_buffer.sv
// Router input port: two VC FIFOs drained round-robin to the core.
// Each drained flit returns one credit upstream the next cycle.
module vc_input_buffer
  import noc_vc_pkg::*;
#(
  parameter int DATA_W = FLIT_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       in_vc,
  input  logic [DATA_W-1:0]          in_flit,
  output logic                       out_valid,
  output logic                       out_vc,
  output logic [DATA_W-1:0]          out_flit,
  input  logic                       out_ready,
  output logic                       credit_valid,
  output logic                       credit_vc,
  output logic [$clog2(DEPTH+1)-1:0] vc0_count,
  output logic [$clog2(DEPTH+1)-1:0] vc1_count,
  output logic                       overflow_err
);

  logic [NUM_VC-1:0] push;
  logic [NUM_VC-1:0] pop;
  logic [NUM_VC-1:0] full;
  logic [NUM_VC-1:0] empty;
  logic [DATA_W-1:0] dout0;
  logic [DATA_W-1:0] dout1;

  vc_id_t rr_last;
  vc_id_t held_vc;
  vc_id_t sel;
  logic   hold;
  logic   hs;
  logic   ovf_hit;

  vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_vc0 (
    .clk   (clk),
    .reset (reset),
    .push  (push[0]),
    .pop   (pop[0]),
    .din   (in_flit),
    .dout  (dout0),
    .count (vc0_count),
    .full  (full[0]),
    .empty (empty[0])
  );

  vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_vc1 (
    .clk   (clk),
    .reset (reset),
    .push  (push[1]),
    .pop   (pop[1]),
    .din   (in_flit),
    .dout  (dout1),
    .count (vc1_count),
    .full  (full[1]),
    .empty (empty[1])
  );

  // Grant: held VC wins, else round-robin, else whichever has data.
  always_comb begin
    sel = 1'b0;
    if (hold)
      sel = held_vc;
    else if (!empty[0] && !empty[1])
      sel = ~rr_last;
    else if (!empty[1])
      sel = 1'b1;
  end

  assign out_valid = hold || !(&empty);
  assign out_vc    = sel;
  assign out_flit  = !out_valid ? '0
                   : sel ? dout1 : dout0;

  assign hs      = out_valid && out_ready;
  assign pop[0]  = hs && !sel;
  assign pop[1]  = hs && sel;
  assign push[0] = in_valid && !in_vc;
  assign push[1] = in_valid && in_vc;
  assign ovf_hit = in_valid && full[in_vc]
                && !pop[in_vc];

  // Arbiter history, grant lock, credit return, sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last      <= 1'b1;
      hold         <= 1'b0;
      held_vc      <= 1'b0;
      credit_valid <= 1'b0;
      credit_vc    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      hold         <= out_valid && !out_ready;
      held_vc      <= sel;
      credit_valid <= hs;
      if (hs) begin
        rr_last   <= sel;
        credit_vc <= sel;
      end
      if (ovf_hit)
        overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Bench for vc_input_buffer: table vectors, directed
// corner sequences and random traffic against a queue model.
module tb_vc_input_buffer;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_vc = 1'b0;
  logic [DW-1:0] in_flit = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic          out_vc;
  logic [DW-1:0] out_flit;
  logic          credit_valid;
  logic          credit_vc;
  logic [CW-1:0] vc0_count;
  logic [CW-1:0] vc1_count;
  logic          overflow_err;

  vc_input_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_vc        (in_vc),
    .in_flit      (in_flit),
    .out_valid    (out_valid),
    .out_vc       (out_vc),
    .out_flit     (out_flit),
    .out_ready    (out_ready),
    .credit_valid (credit_valid),
    .credit_vc    (credit_vc),
    .vc0_count    (vc0_count),
    .vc1_count    (vc1_count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: flit queues plus arbitration history.
  logic [DW-1:0] mq0[$];
  logic [DW-1:0] mq1[$];
  logic m_rr;
  logic m_lock;
  logic m_lock_vc;
  logic m_cv;
  logic m_cvc;
  logic m_ovf;

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    m_rr = 1'b1;
    m_lock = 1'b0;
    m_lock_vc = 1'b0;
    m_cv = 1'b0;
    m_cvc = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Drive inputs after the falling edge and let outputs settle.
  task automatic apply(input logic iv, input logic ivc,
                       input logic [DW-1:0] f,
                       input logic rdy);
    @(negedge clk);
    in_valid = iv;
    in_vc = ivc;
    in_flit = f;
    out_ready = rdy;
    #1;
  endtask

  // Compare against model, then advance model by one edge.
  task automatic model_step();
    int n0, n1;
    logic ev, evc, hs, acc;
    logic [DW-1:0] ef;
    n0 = mq0.size();
    n1 = mq1.size();
    ev = (n0 != 0) || (n1 != 0);
    if (m_lock) evc = m_lock_vc;
    else if (n0 != 0 && n1 != 0) evc = ~m_rr;
    else evc = (n1 != 0);
    ef = '0;
    if (ev) ef = evc ? mq1[0] : mq0[0];
    chk("out_valid", DW'(out_valid), DW'(ev));
    if (ev) chk("out_vc", DW'(out_vc), DW'(evc));
    chk("out_flit", out_flit, ef);
    chk("credit_valid", DW'(credit_valid), DW'(m_cv));
    if (m_cv)
      chk("credit_vc", DW'(credit_vc), DW'(m_cvc));
    chk("vc0_count", DW'(vc0_count), DW'(n0));
    chk("vc1_count", DW'(vc1_count), DW'(n1));
    chk("overflow_err", DW'(overflow_err), DW'(m_ovf));
    hs = ev && out_ready;
    if (hs) begin
      if (evc) void'(mq1.pop_front());
      else void'(mq0.pop_front());
      m_rr = evc;
    end
    if (in_valid) begin
      acc = ((in_vc ? n1 : n0) < DEPTH)
         || (hs && evc == in_vc);
      if (!acc) m_ovf = 1'b1;
      else if (in_vc) mq1.push_back(in_flit);
      else mq0.push_back(in_flit);
    end
    m_lock = ev && !out_ready;
    m_lock_vc = evc;
    m_cv = hs;
    m_cvc = evc;
  endtask

  task automatic cyc(input logic iv, input logic ivc,
                     input logic [DW-1:0] f,
                     input logic rdy);
    apply(iv, ivc, f, rdy);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst out_valid", DW'(out_valid), '0);
    chk("rst out_vc", DW'(out_vc), '0);
    chk("rst out_flit", out_flit, '0);
    chk("rst credit_valid", DW'(credit_valid), '0);
    chk("rst credit_vc", DW'(credit_vc), '0);
    chk("rst vc0_count", DW'(vc0_count), '0);
    chk("rst vc1_count", DW'(vc1_count), '0);
    chk("rst overflow_err", DW'(overflow_err), '0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic          iv;
    logic          ivc;
    logic [DW-1:0] f;
    logic          rdy;
    logic          e_valid;
    logic          e_vc;
    logic [DW-1:0] e_flit;
    logic          e_cv;
    logic [CW-1:0] e_c0;
  } vec_t;

  vec_t vt[5];

  initial begin
    // Two flits on VC0 straight through with ready high.
    vt[0] = '{1, 0, 32'hA0, 1, 0, 0, 32'h0,  0, 3'd0};
    vt[1] = '{1, 0, 32'hA1, 1, 1, 0, 32'hA0, 0, 3'd1};
    vt[2] = '{0, 0, 32'h0,  1, 1, 0, 32'hA1, 1, 3'd1};
    vt[3] = '{0, 0, 32'h0,  1, 0, 0, 32'h0,  1, 3'd0};
    vt[4] = '{0, 0, 32'h0,  1, 0, 0, 32'h0,  0, 3'd0};

    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    for (int i = 0; i < 5; i++) begin
      apply(vt[i].iv, vt[i].ivc, vt[i].f, vt[i].rdy);
      chk($sformatf("tv%0d out_valid", i),
          DW'(out_valid), DW'(vt[i].e_valid));
      chk($sformatf("tv%0d out_vc", i),
          DW'(out_vc), DW'(vt[i].e_vc));
      chk($sformatf("tv%0d out_flit", i),
          out_flit, vt[i].e_flit);
      chk($sformatf("tv%0d credit_valid", i),
          DW'(credit_valid), DW'(vt[i].e_cv));
      if (vt[i].e_cv)
        chk($sformatf("tv%0d credit_vc", i),
            DW'(credit_vc), '0);
      chk($sformatf("tv%0d vc0_count", i),
          DW'(vc0_count), DW'(vt[i].e_c0));
      model_step();
    end

    // Both VCs loaded, then drained: alternation from VC0.
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 32'h10 + i, 0);
    for (int i = 0; i < 4; i++)
      cyc(1, 1, 32'h20 + i, 0);
    for (int i = 0; i < 10; i++)
      cyc(0, 0, 0, 1);

    // Grant lock on VC1 while VC0 arrives mid-stall.
    cyc(1, 1, 32'h55, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 32'h66, 0);
    cyc(0, 0, 0, 0);
    chk("lock out_vc", DW'(out_vc), 32'd1);
    chk("lock out_flit", out_flit, 32'h55);
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 1);

    // Overflow: fifth push to a full VC0 is dropped.
    for (int i = 0; i < 5; i++)
      cyc(1, 0, 32'hB0 + i, 0);
    cyc(0, 0, 0, 0);
    chk("ovf count", DW'(vc0_count), 32'd4);
    chk("ovf flag", DW'(overflow_err), 32'd1);
    for (int i = 0; i < 6; i++)
      cyc(0, 0, 0, 1);

    // Full VC1 accepts a push when popped the same cycle.
    do_reset();
    for (int i = 0; i < 4; i++)
      cyc(1, 1, 32'hC0 + i, 0);
    cyc(1, 1, 32'hC4, 1);
    cyc(0, 0, 0, 0);
    chk("full pp count", DW'(vc1_count), 32'd4);
    chk("full pp ovf", DW'(overflow_err), 32'd0);
    for (int i = 0; i < 6; i++)
      cyc(0, 0, 0, 1);

    // Mid-operation reset, then VC1 is served first.
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 32'hD0 + i, 0);
      cyc(1, 1, 32'hE0 + i, 0);
    end
    do_reset();
    cyc(1, 1, 32'hF1, 0);
    cyc(0, 0, 0, 1);
    chk("post rst vc", DW'(out_vc), 32'd1);
    cyc(0, 0, 0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 4) != 0, $urandom % 2,
          $urandom, ($urandom % 3) != 0);
    for (int i = 0; i < 12; i++)
      cyc(0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
